fd_hazard_ctrl: RTL and testbench
=================================

Name: fd_hazard_ctrl

Overview:
- Front-end pipeline sequencer that drives the fetch/decode pipeline register and the PC register.
- Decides every cycle whether to advance, freeze, or squash the fetch/decode register.
- Decisions cover jump shadows, load-use hazards, external memory stalls and the halt opcode.
- Owns the halt and jump-shadow state; the fetch/decode register becomes a plain enable/flush register under its control.

Parameters:
- HALT_OP, 6'b111111: opcode in decode that halts the pipeline.
- SHADOW_CYCLES, 2: fetch slots squashed after a taken jump. Legal range 1..3.
- LU_STALL_CYCLES, 1: bubble cycles inserted per load-use hazard. Legal range 1..3.

Ports:
- clk  in  1: clock, rising edge.
- rstd  in  1: asynchronous reset, active-high.
- op_d  in  6: opcode of the instruction in decode.
- jon_d  in  2: jump indication from decode. Bit1 = taken jump resolved; bit0 = jump/branch being decoded.
- rs_d  in  5: decode source register 1.
- rt_d  in  5: decode source register 2.
- load_e  in  1: execute stage holds a load.
- rd_e  in  5: execute stage destination register.
- ext_stall  in  1: memory busy; freeze the front end.
- pc_en  out  1: PC register load enable.
- fd_en  out  1: fetch/decode register capture enable.
- fd_flush  out  1: load NOP 32'hdc000000 into the fetch/decode register (overrides fd_en).
- de_flush  out  1: inject a bubble into decode/execute.
- halted  out  1: pipeline halted.
- state  out  2: 0 RUN, 1 SHADOW, 2 LUSTALL, 3 HALT.
- stall_count  out  16: saturating count of cycles with pc_en=0 while not halted.

Behaviour:
- Reset (rstd=1, asynchronous) sets:
  - state=RUN, shadow cnt=0, lu cnt=0, stall_count=0.
  - Outputs while in reset: pc_en=0, fd_en=0, fd_flush=1, de_flush=0, halted=0.
- Outputs are combinational from state plus the current inputs. The state and counters update on the rising clk edge.
- Load-use hazard: lu = load_e & (rd_e!=0) & (rd_e==rs_d | rd_e==rt_d).
- In RUN, conditions are evaluated in this priority order:
  1. op_d==HALT_OP: fd_flush=1, pc_en=0, de_flush=0. Next state HALT.
  2. jon_d!=0: pc_en=1, fd_flush=1. If jon_d[1]: load shadow cnt=SHADOW_CYCLES and go to SHADOW. Otherwise stay in RUN.
  3. ext_stall: pc_en=0, fd_en=0, fd_flush=0, de_flush=0. Stay in RUN.
  4. lu: pc_en=0, fd_en=0, de_flush=1. Load lu cnt=LU_STALL_CYCLES-1. Next state is LUSTALL if that value is non-zero, otherwise RUN.
  5. Otherwise: pc_en=1, fd_en=1, all flushes 0.
- SHADOW:
  - fd_flush=1 and pc_en=1 every cycle.
  - cnt decrements; when cnt==1 the next state is RUN.
  - jon_d[1]=1 reloads cnt=SHADOW_CYCLES.
  - ext_stall: pc_en=0 and cnt holds (fd_flush stays 1).
  - op_d==HALT_OP: go to HALT (takes priority over the jump reload).
- LUSTALL:
  - Same outputs as the RUN lu case.
  - lu cnt decrements; next state is RUN when lu cnt==1.
  - ext_stall holds the count.
- HALT:
  - pc_en=0, fd_en=0, fd_flush=1, de_flush=1, halted=1.
  - Ignores all inputs. Exits only via reset.
- stall_count increments when pc_en==0 and state!=HALT and rstd==0. It saturates at 16'hffff.
- Simultaneous events follow the priority above: halt > jump > ext_stall > load-use. A jump during ext_stall still flushes but does not load the PC.
- Reset asserted mid-SHADOW or mid-HALT returns immediately to RUN with all counters cleared.

Test Plan:
- Reset, then 4 cycles of plain op_d=0, jon_d=0 -> pc_en=1, fd_en=1, fd_flush=0, state=0, stall_count=0.
- jon_d=2'b10 for 1 cycle in RUN -> fd_flush=1 that cycle and the next 2 cycles (state=1 for 2 cycles), then state=0. pc_en stays 1 throughout.
- load_e=1, rd_e=5, rs_d=5 for 1 cycle -> pc_en=0, fd_en=0, de_flush=1 that cycle, stall_count=1. With rd_e=0 instead -> no stall.
- ext_stall=1 for 3 cycles during SHADOW with cnt=2 -> cnt holds, pc_en=0, stall_count rises by 3. SHADOW completes 2 cycles after ext_stall drops.
- op_d=6'b111111 with jon_d=2'b10 in the same cycle -> state=HALT next cycle, halted=1, fd_flush=1. Later jumps are ignored and stall_count freezes.
- Assert rstd while in HALT -> state=0, halted=0, stall_count=0 immediately (asynchronous). After release -> normal RUN outputs.

Source files
------------

// File: rtl/fd_hazard_ctrl.sv
// Front-end sequencer for the fetch/decode register and PC: decides each cycle
// whether the front end advances, freezes or squashes, and owns halt/jump-shadow state.
module fd_hazard_ctrl #(
  parameter logic [5:0] HALT_OP         = 6'b111111,
  parameter int         SHADOW_CYCLES   = 2,
  parameter int         LU_STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rstd,
  input  logic [5:0]  op_d,
  input  logic [1:0]  jon_d,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic        load_e,
  input  logic [4:0]  rd_e,
  input  logic        ext_stall,
  output logic        pc_en,
  output logic        fd_en,
  output logic        fd_flush,
  output logic        de_flush,
  output logic        halted,
  output logic [1:0]  state,
  output logic [15:0] stall_count
);

  // Handshake: there is no valid/ready pair here; pc_en and fd_en are
  // same-cycle enables and fd_flush always wins over fd_en at the register.

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SHADOW  = 2'd1,
    ST_LUSTALL = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  localparam logic [1:0] SHADOW_LOAD = 2'(SHADOW_CYCLES);
  localparam logic [1:0] LU_LOAD     = 2'(LU_STALL_CYCLES - 1);

  state_t      state_q, state_n;
  logic [1:0]  shadow_cnt_q, shadow_cnt_n;
  logic [1:0]  lu_cnt_q, lu_cnt_n;
  logic [15:0] stall_count_q;

  logic is_halt_op;
  logic lu;
  logic pc_en_c, fd_en_c, fd_flush_c, de_flush_c;

  assign is_halt_op = (op_d == HALT_OP);
  assign lu = load_e && (rd_e != 5'd0) && ((rd_e == rs_d) || (rd_e == rt_d));

  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      state_q      <= ST_RUN;
      shadow_cnt_q <= 2'd0;
      lu_cnt_q     <= 2'd0;
    end else begin
      state_q      <= state_n;
      shadow_cnt_q <= shadow_cnt_n;
      lu_cnt_q     <= lu_cnt_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    shadow_cnt_n = shadow_cnt_q;
    lu_cnt_n     = lu_cnt_q;
    pc_en_c      = 1'b0;
    fd_en_c      = 1'b0;
    fd_flush_c   = 1'b0;
    de_flush_c   = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (is_halt_op) begin
          fd_flush_c = 1'b1;
          state_n    = ST_HALT;
        end else if (jon_d != 2'b00) begin
          // A jump under ext_stall still squashes the slot but cannot load the PC.
          pc_en_c    = !ext_stall;
          fd_flush_c = 1'b1;
          if (jon_d[1]) begin
            shadow_cnt_n = SHADOW_LOAD;
            state_n      = ST_SHADOW;
          end
        end else if (ext_stall) begin
          state_n = ST_RUN;
        end else if (lu) begin
          de_flush_c = 1'b1;
          lu_cnt_n   = LU_LOAD;
          state_n    = (LU_LOAD != 2'd0) ? ST_LUSTALL : ST_RUN;
        end else begin
          pc_en_c = 1'b1;
          fd_en_c = 1'b1;
        end
      end

      ST_SHADOW: begin
        fd_flush_c = 1'b1;
        pc_en_c    = !ext_stall;
        if (is_halt_op) begin
          state_n = ST_HALT;
        end else if (jon_d[1]) begin
          shadow_cnt_n = SHADOW_LOAD;
        end else if (ext_stall) begin
          shadow_cnt_n = shadow_cnt_q;
        end else if (shadow_cnt_q <= 2'd1) begin
          shadow_cnt_n = 2'd0;
          state_n      = ST_RUN;
        end else begin
          shadow_cnt_n = shadow_cnt_q - 2'd1;
        end
      end

      ST_LUSTALL: begin
        de_flush_c = 1'b1;
        if (ext_stall) begin
          lu_cnt_n = lu_cnt_q;
        end else if (lu_cnt_q <= 2'd1) begin
          lu_cnt_n = 2'd0;
          state_n  = ST_RUN;
        end else begin
          lu_cnt_n = lu_cnt_q - 2'd1;
        end
      end

      ST_HALT: begin
        fd_flush_c = 1'b1;
        de_flush_c = 1'b1;
      end

      default: begin
        state_n = ST_RUN;
      end
    endcase
  end

  // Reset holds the front end frozen with a NOP in the fetch/decode register.
  always_comb begin
    if (rstd) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      fd_flush = 1'b1;
      de_flush = 1'b0;
      halted   = 1'b0;
    end else begin
      pc_en    = pc_en_c;
      fd_en    = fd_en_c;
      fd_flush = fd_flush_c;
      de_flush = de_flush_c;
      halted   = (state_q == ST_HALT);
    end
  end

  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      stall_count_q <= 16'd0;
    end else if (!pc_en && (state_q != ST_HALT) && (stall_count_q != 16'hffff)) begin
      stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign state       = state_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fd_hazard_ctrl.sv
// Bench for fd_hazard_ctrl: directed vectors, a cycle-level behavioural model
// checked on every negedge, and hand-computed literal expectations.
module tb_fd_hazard_ctrl;

  localparam logic [5:0] HALT_OP = 6'b111111;
  localparam int SHADOW_CYCLES   = 2;
  localparam int LU_STALL_CYCLES = 1;

  logic        clk;
  logic        rstd;
  logic [5:0]  op_d;
  logic [1:0]  jon_d;
  logic [4:0]  rs_d, rt_d, rd_e;
  logic        load_e, ext_stall;
  logic        pc_en, fd_en, fd_flush, de_flush, halted;
  logic [1:0]  state;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  fd_hazard_ctrl #(
    .HALT_OP(HALT_OP), .SHADOW_CYCLES(SHADOW_CYCLES), .LU_STALL_CYCLES(LU_STALL_CYCLES)
  ) dut (
    .clk(clk), .rstd(rstd), .op_d(op_d), .jon_d(jon_d), .rs_d(rs_d), .rt_d(rt_d),
    .load_e(load_e), .rd_e(rd_e), .ext_stall(ext_stall),
    .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush), .de_flush(de_flush),
    .halted(halted), .state(state), .stall_count(stall_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 running, 1 squashing jump shadow, 2 bubbling, 3 halted.
  int m_mode = 0, m_slots = 0, m_bubbles = 0, m_stalls = 0;
  int n_mode, n_slots, n_bubbles, n_stalls;

  always @(posedge clk or posedge rstd) begin
    if (rstd) begin
      m_mode = 0; m_slots = 0; m_bubbles = 0; m_stalls = 0;
    end else begin
      m_mode = n_mode; m_slots = n_slots; m_bubbles = n_bubbles; m_stalls = n_stalls;
    end
  end

  always @(negedge clk) begin
    bit e_pc, e_fe, e_ff, e_df, hazard;
    if (!rstd) begin
      hazard = load_e && (rd_e != 0) && (rd_e == rs_d || rd_e == rt_d);
      e_pc = 0; e_fe = 0; e_ff = 0; e_df = 0;
      n_mode = m_mode; n_slots = m_slots; n_bubbles = m_bubbles;
      if (m_mode == 3) begin
        e_ff = 1; e_df = 1;
      end else if (m_mode == 2) begin
        e_df = 1;
        if (!ext_stall) begin
          n_bubbles = m_bubbles - 1;
          if (n_bubbles <= 0) begin n_bubbles = 0; n_mode = 0; end
        end
      end else if (m_mode == 1) begin
        e_ff = 1; e_pc = !ext_stall;
        if (op_d == HALT_OP) n_mode = 3;
        else if (jon_d[1]) n_slots = SHADOW_CYCLES;
        else if (!ext_stall) begin
          n_slots = m_slots - 1;
          if (n_slots <= 0) begin n_slots = 0; n_mode = 0; end
        end
      end else begin
        if (op_d == HALT_OP) begin
          e_ff = 1; n_mode = 3;
        end else if (jon_d != 0) begin
          e_ff = 1; e_pc = !ext_stall;
          if (jon_d[1]) begin n_mode = 1; n_slots = SHADOW_CYCLES; end
        end else if (ext_stall) begin
          e_pc = 0;
        end else if (hazard) begin
          e_df = 1; n_bubbles = LU_STALL_CYCLES - 1;
          n_mode = (n_bubbles > 0) ? 2 : 0;
        end else begin
          e_pc = 1; e_fe = 1;
        end
      end
      n_stalls = m_stalls;
      if (!e_pc && m_mode != 3 && m_stalls < 65535) n_stalls = m_stalls + 1;

      check("m_pc_en", 32'(pc_en), 32'(e_pc));
      check("m_fd_en", 32'(fd_en), 32'(e_fe));
      check("m_fd_flush", 32'(fd_flush), 32'(e_ff));
      check("m_de_flush", 32'(de_flush), 32'(e_df));
      check("m_halted", 32'(halted), 32'(m_mode == 3));
      check("m_state", 32'(state), 32'(m_mode));
      check("m_stall_count", 32'(stall_count), 32'(m_stalls));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply(input logic [5:0] op, input logic [1:0] jon, input logic [4:0] rs,
                       input logic [4:0] rt, input logic ld, input logic [4:0] rd, input logic ext);
    op_d = op; jon_d = jon; rs_d = rs; rt_d = rt; load_e = ld; rd_e = rd; ext_stall = ext;
    #2;
  endtask

  task automatic idle();
    apply(6'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [5:0] op; logic [1:0] jon; logic [4:0] rs, rt; logic ld; logic [4:0] rd; logic ext;
  } vec_t;

  vec_t tbl [0:13];

  // ---------------- stimulus ----------------
  initial begin
    tbl = '{
      '{6'd0,  2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0},
      '{6'd4,  2'b01, 5'd2, 5'd3, 1'b0, 5'd0, 1'b0},
      '{6'd0,  2'b00, 5'd3, 5'd0, 1'b1, 5'd3, 1'b1},
      '{6'd0,  2'b00, 5'd1, 5'd9, 1'b1, 5'd9, 1'b0},
      '{6'd0,  2'b10, 5'd6, 5'd0, 1'b1, 5'd6, 1'b0},
      '{6'd0,  2'b10, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0},
      '{6'd0,  2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0},
      '{6'd0,  2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1},
      '{6'd0,  2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0},
      '{6'd0,  2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0},
      '{6'd0,  2'b00, 5'd4, 5'd0, 1'b1, 5'd4, 1'b0},
      '{6'd0,  2'b10, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0},
      '{HALT_OP, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0},
      '{6'd0,  2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0}
    };

    rstd = 1'b1;
    op_d = 6'd0; jon_d = 2'b00; rs_d = 5'd0; rt_d = 5'd0; load_e = 1'b0; rd_e = 5'd0; ext_stall = 1'b0;
    #1;
    check("rst_pc_en", 32'(pc_en), 32'd0);
    check("rst_fd_en", 32'(fd_en), 32'd0);
    check("rst_fd_flush", 32'(fd_flush), 32'd1);
    check("rst_de_flush", 32'(de_flush), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_stall_count", 32'(stall_count), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rstd = 1'b0;

    // plain run
    repeat (3) begin idle(); tick(); end
    idle();
    check("run_pc_en", 32'(pc_en), 32'd1);
    check("run_fd_en", 32'(fd_en), 32'd1);
    check("run_fd_flush", 32'(fd_flush), 32'd0);
    check("run_state", 32'(state), 32'd0);
    check("run_stall_count", 32'(stall_count), 32'd0);
    tick();

    // taken jump: flush this cycle plus two shadow slots
    apply(6'd0, 2'b10, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    check("jmp0_fd_flush", 32'(fd_flush), 32'd1);
    check("jmp0_pc_en", 32'(pc_en), 32'd1);
    tick(); idle();
    check("jmp1_state", 32'(state), 32'd1);
    check("jmp1_fd_flush", 32'(fd_flush), 32'd1);
    check("jmp1_pc_en", 32'(pc_en), 32'd1);
    tick(); idle();
    check("jmp2_state", 32'(state), 32'd1);
    check("jmp2_fd_flush", 32'(fd_flush), 32'd1);
    tick(); idle();
    check("jmp3_state", 32'(state), 32'd0);
    check("jmp3_fd_flush", 32'(fd_flush), 32'd0);
    tick();

    // load-use hazards
    apply(6'd0, 2'b00, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0);
    check("lu_pc_en", 32'(pc_en), 32'd0);
    check("lu_fd_en", 32'(fd_en), 32'd0);
    check("lu_de_flush", 32'(de_flush), 32'd1);
    tick();
    apply(6'd0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    check("lu_r0_pc_en", 32'(pc_en), 32'd1);
    check("lu_r0_de_flush", 32'(de_flush), 32'd0);
    check("lu_stall_count", 32'(stall_count), 32'd1);
    tick();
    apply(6'd0, 2'b00, 5'd3, 5'd7, 1'b1, 5'd7, 1'b0);
    check("lu_rt_de_flush", 32'(de_flush), 32'd1);
    tick(); idle();
    check("lu_rt_stall_count", 32'(stall_count), 32'd2);
    tick();

    // ext_stall inside a jump shadow
    apply(6'd0, 2'b10, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    apply(6'd0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
    check("shx_state", 32'(state), 32'd1);
    check("shx_pc_en", 32'(pc_en), 32'd0);
    check("shx_fd_flush", 32'(fd_flush), 32'd1);
    tick(); tick(); tick();
    idle();
    check("shx_after_state", 32'(state), 32'd1);
    check("shx_stall_count", 32'(stall_count), 32'd5);
    tick(); idle();
    check("shx_tail_state", 32'(state), 32'd1);
    tick(); idle();
    check("shx_done_state", 32'(state), 32'd0);
    tick();
    apply(6'd0, 2'b01, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
    check("jx_fd_flush", 32'(fd_flush), 32'd1);
    check("jx_pc_en", 32'(pc_en), 32'd0);
    tick(); idle();
    check("jx_stall_count", 32'(stall_count), 32'd6);
    tick();

    // halt beats a simultaneous jump
    apply(HALT_OP, 2'b10, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    check("hlt0_pc_en", 32'(pc_en), 32'd0);
    check("hlt0_fd_flush", 32'(fd_flush), 32'd1);
    tick();
    apply(6'd0, 2'b10, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    check("hlt1_state", 32'(state), 32'd3);
    check("hlt1_halted", 32'(halted), 32'd1);
    check("hlt1_de_flush", 32'(de_flush), 32'd1);
    check("hlt1_stall_count", 32'(stall_count), 32'd7);
    tick();
    apply(6'd0, 2'b10, 5'd5, 5'd0, 1'b1, 5'd5, 1'b1);
    tick(); idle();
    check("hlt2_state", 32'(state), 32'd3);
    check("hlt2_stall_count", 32'(stall_count), 32'd7);

    // asynchronous reset out of HALT
    rstd = 1'b1;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_halted", 32'(halted), 32'd0);
    check("arst_stall_count", 32'(stall_count), 32'd0);
    check("arst_fd_flush", 32'(fd_flush), 32'd1);
    tick(); tick();
    rstd = 1'b0;
    idle();
    check("post_pc_en", 32'(pc_en), 32'd1);
    check("post_fd_en", 32'(fd_en), 32'd1);
    check("post_fd_flush", 32'(fd_flush), 32'd0);
    tick();

    // mixed directed vectors, checked by the model
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].op, tbl[i].jon, tbl[i].rs, tbl[i].rt, tbl[i].ld, tbl[i].rd, tbl[i].ext);
      tick();
    end
    idle();
    check("tbl_final_state", 32'(state), 32'd3);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
